// File: rtl/seven_seg_scan_decoder.sv
// Seven-segment scan decoder.
// Watches a multiplexed seven-segment bus (active-low one-hot anodes, active-high abcdefg
// segments), recovers the hex nibble shown on each digit once its pattern has been stable,
// and publishes a complete frame of all digits on a valid/ready output.
module seven_seg_scan_decoder #(
    parameter int unsigned N_DIGITS      = 8,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DIGITS-1:0]   anodes_n,
    input  logic [6:0]            segments,
    output logic [4*N_DIGITS-1:0] frame_value,
    output logic [N_DIGITS-1:0]   frame_err,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  overrun
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHeld
    } state_e;

    state_e                  state_q;
    logic [7:0]              cnt_q;
    logic [N_DIGITS+6:0]     prev_q;
    logic [N_DIGITS-1:0]     seen_q;
    logic [4*N_DIGITS-1:0]   work_val_q;
    logic [N_DIGITS-1:0]     work_err_q;

    logic [N_DIGITS-1:0]     sel;
    logic                    sample_valid;
    logic                    sample_same;
    logic                    capture;
    logic                    all_seen;
    logic                    complete_load;
    logic                    complete_drop;
    logic [3:0]              nib;
    logic                    seg_err;

    // Classify the current bus sample and decide capture / frame completion for this edge.
    always_comb begin
        sel           = ~anodes_n;
        // Exactly one digit selected: non-zero and a power of two.
        sample_valid  = (sel != '0) && ((sel & (sel - N_DIGITS'(1))) == '0);
        sample_same   = ({anodes_n, segments} == prev_q);
        capture       = (state_q == StSettle) && sample_valid && sample_same &&
                        ((cnt_q + 8'd1) == STABLE_CNT);
        all_seen      = &seen_q;
        complete_load = all_seen && (!frame_valid || frame_ready);
        complete_drop = all_seen && frame_valid && !frame_ready;
    end

    // Segment pattern to hex nibble; anything outside the table flags an error.
    always_comb begin
        nib     = 4'h0;
        seg_err = 1'b0;
        case (segments)
            7'b1111110: nib = 4'h0;
            7'b0110000: nib = 4'h1;
            7'b1101101: nib = 4'h2;
            7'b1111001: nib = 4'h3;
            7'b0110011: nib = 4'h4;
            7'b1011011: nib = 4'h5;
            7'b1011111: nib = 4'h6;
            7'b1110000: nib = 4'h7;
            7'b1111111: nib = 4'h8;
            7'b1111011: nib = 4'h9;
            7'b1110111: nib = 4'hA;
            7'b0011111: nib = 4'hB;
            7'b1001110: nib = 4'hC;
            7'b0111101: nib = 4'hD;
            7'b1001111: nib = 4'hE;
            7'b1000111: nib = 4'hF;
            default:    seg_err = 1'b1;
        endcase
    end

    // Stability FSM, digit capture, frame assembly and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            prev_q      <= '0;
            seen_q      <= '0;
            work_val_q  <= '0;
            work_err_q  <= '0;
            frame_value <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            prev_q  <= {anodes_n, segments};
            overrun <= complete_drop;

            unique case (state_q)
                StIdle: begin
                    if (sample_valid) begin
                        state_q <= StSettle;
                        cnt_q   <= 8'd1;
                    end
                end
                StSettle: begin
                    if (!sample_valid) begin
                        state_q <= StIdle;
                    end else if (!sample_same) begin
                        cnt_q <= 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (capture) begin
                            state_q <= StHeld;
                        end
                    end
                end
                StHeld: begin
                    // Stable pattern already captured; only a change re-arms the counter.
                    if (!sample_valid) begin
                        state_q <= StIdle;
                    end else if (!sample_same) begin
                        state_q <= StSettle;
                        cnt_q   <= 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            for (int i = 0; i < int'(N_DIGITS); i++) begin
                if (capture && sel[i]) begin
                    work_val_q[4*i +: 4] <= nib;
                    work_err_q[i]        <= seg_err;
                end
            end

            // A capture coinciding with completion belongs to the next frame.
            seen_q <= (all_seen ? '0 : seen_q) | (capture ? sel : '0);

            if (complete_load) begin
                frame_value <= work_val_q;
                frame_err   <= work_err_q;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder with two digits and a four-sample stability window.
module tb_seven_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] anodes_n;
    logic [6:0] segments;
    logic [7:0] frame_value;
    logic [1:0] frame_err;
    logic       frame_valid;
    logic       frame_ready;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_decoder #(
        .N_DIGITS      (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .anodes_n    (anodes_n),
        .segments    (segments),
        .frame_value (frame_value),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle past it before looking at outputs or changing inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] an, input logic [6:0] seg, input int n);
        anodes_n = an;
        segments = seg;
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [7:0] val,
                             input logic [1:0] err, input logic ovr);
        check({tag, ".valid"}, 8'(frame_valid), 8'(v));
        check({tag, ".value"}, frame_value, val);
        check({tag, ".err"}, 8'(frame_err), 8'(err));
        check({tag, ".overrun"}, 8'(overrun), 8'(ovr));
    endtask

    initial begin
        reset       = 1'b1;
        anodes_n    = 2'b11;
        segments    = 7'b0000000;
        frame_ready = 1'b0;
        tick();
        tick();
        check_all("reset", 1'b0, 8'h00, 2'b00, 1'b0);
        reset = 1'b0;

        // Clean scan: digit0 = 3, digit1 = B.
        frame_ready = 1'b1;
        drive(2'b10, 7'b1111001, 6);
        drive(2'b01, 7'b0011111, 4);
        check("clean.before", 8'(frame_valid), 8'h00);
        tick();
        check_all("clean.frame", 1'b1, 8'hB3, 2'b00, 1'b0);
        tick();
        check("clean.accept", 8'(frame_valid), 8'h00);
        drive(2'b11, 7'b0000000, 2);

        // Glitch rejection: digit1 = 7, digit0 = 5 with a one-cycle glitch after 3 samples.
        drive(2'b01, 7'b1110000, 4);
        drive(2'b10, 7'b1011011, 3);
        drive(2'b10, 7'b1011111, 1);
        drive(2'b10, 7'b1011011, 4);
        check("glitch.before", 8'(frame_valid), 8'h00);
        tick();
        check_all("glitch.frame", 1'b1, 8'h75, 2'b00, 1'b0);
        tick();
        check("glitch.accept", 8'(frame_valid), 8'h00);
        drive(2'b11, 7'b0000000, 2);

        // Invalid anodes never capture; digit0 must still be missing afterwards.
        drive(2'b00, 7'b1111110, 6);
        drive(2'b11, 7'b1111110, 3);
        drive(2'b01, 7'b0110000, 5);
        check("invalid.nocap", 8'(frame_valid), 8'h00);
        drive(2'b10, 7'b1111110, 4);
        check("invalid.before", 8'(frame_valid), 8'h00);
        tick();
        check_all("invalid.frame", 1'b1, 8'h10, 2'b00, 1'b0);
        tick();
        check("invalid.accept", 8'(frame_valid), 8'h00);
        drive(2'b11, 7'b0000000, 2);

        // Blank digit1 decodes to 0 with its error bit set.
        drive(2'b10, 7'b1001111, 4);
        drive(2'b01, 7'b0000000, 5);
        check_all("err.frame", 1'b1, 8'h0E, 2'b10, 1'b0);
        tick();
        check("err.accept", 8'(frame_valid), 8'h00);
        drive(2'b11, 7'b0000000, 2);

        // Backpressure: F0 = CA held, F1 = FD dropped with an overrun pulse.
        frame_ready = 1'b0;
        drive(2'b10, 7'b1110111, 4);
        drive(2'b01, 7'b1001110, 5);
        check_all("bp.f0", 1'b1, 8'hCA, 2'b00, 1'b0);
        drive(2'b10, 7'b0111101, 4);
        drive(2'b01, 7'b1000111, 4);
        check("bp.no_ovr_yet", 8'(overrun), 8'h00);
        tick();
        check_all("bp.overrun", 1'b1, 8'hCA, 2'b00, 1'b1);
        tick();
        check_all("bp.held", 1'b1, 8'hCA, 2'b00, 1'b0);
        frame_ready = 1'b1;
        tick();
        check("bp.accept", 8'(frame_valid), 8'h00);
        check("bp.accept_ovr", 8'(overrun), 8'h00);
        drive(2'b11, 7'b0000000, 2);

        // Accept and load on the same edge: valid stays high with the new frame.
        frame_ready = 1'b0;
        drive(2'b10, 7'b1101101, 4);
        drive(2'b01, 7'b0110011, 5);
        check_all("hand.f2", 1'b1, 8'h42, 2'b00, 1'b0);
        drive(2'b10, 7'b1011111, 4);
        drive(2'b01, 7'b1111011, 4);
        frame_ready = 1'b1;
        tick();
        check_all("hand.load", 1'b1, 8'h96, 2'b00, 1'b0);
        tick();
        check("hand.accept", 8'(frame_valid), 8'h00);
        drive(2'b11, 7'b0000000, 2);

        // Reset with a pending frame and a half-scanned one.
        frame_ready = 1'b0;
        drive(2'b10, 7'b1111111, 4);
        drive(2'b01, 7'b1111111, 5);
        check_all("rst.pending", 1'b1, 8'h88, 2'b00, 1'b0);
        drive(2'b10, 7'b1111001, 4);
        reset = 1'b1;
        tick();
        check_all("rst.mid", 1'b0, 8'h00, 2'b00, 1'b0);
        reset       = 1'b0;
        frame_ready = 1'b1;
        drive(2'b01, 7'b0110000, 5);
        check("rst.fresh", 8'(frame_valid), 8'h00);
        drive(2'b10, 7'b1011011, 4);
        tick();
        check_all("rst.frame", 1'b1, 8'h15, 2'b00, 1'b0);
        tick();
        check("rst.accept", 8'(frame_valid), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
